// File: rtl/serial_word_deserializer_pkg.sv
// Shared types and helpers for the serial word deserializer.
package serial_word_deserializer_pkg;

  // Collect bits until the word is complete; hold it when the output register is busy.
  typedef enum logic {
    StCollect = 1'b0,
    StHold    = 1'b1
  } state_e;

  // Counter width able to represent 0..width inclusive.
  function automatic int unsigned cnt_width(input int unsigned width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/word_hold_reg.sv
// Single-entry valid/ready output register for assembled words.
module word_hold_reg #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  input  logic             ready,
  output logic [WIDTH-1:0] data,
  output logic             valid,
  output logic             out_free
);

  // Register is free when empty or its word is being accepted this cycle.
  assign out_free = !valid || ready;

  // Load a new word, or drop valid once the consumer accepts the current one.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      data  <= '0;
      valid <= 1'b0;
    end else if (load && out_free) begin
      data  <= load_data;
      valid <= 1'b1;
    end else if (ready) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/serial_word_deserializer.sv
// Assembles qualified serial bits into WIDTH-bit words with one word of stall slack.
module serial_word_deserializer
  import serial_word_deserializer_pkg::*;
#(
  parameter int unsigned WIDTH     = 8,
  parameter bit          MSB_FIRST = 1'b1,
  localparam int unsigned CW       = cnt_width(WIDTH)
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             bit_in,
  input  logic             bit_valid,
  input  logic             flush,
  output logic [WIDTH-1:0] word_out,
  output logic             word_valid,
  input  logic             word_ready,
  output logic [CW-1:0]    bit_count,
  output logic             overrun
);

  logic [WIDTH-1:0] sh_q;
  logic [WIDTH-1:0] sh_next;
  logic [WIDTH-1:0] load_data;
  logic [CW-1:0]    cnt_q;
  state_e           state_q;
  logic             overrun_q;
  logic             out_free;
  logic             last_bit;
  logic             load;

  // Next shifter value and the decision to hand a word to the output register.
  always_comb begin
    if (MSB_FIRST) begin
      sh_next = {sh_q[WIDTH-2:0], bit_in};
    end else begin
      sh_next = {bit_in, sh_q[WIDTH-1:1]};
    end
    last_bit = bit_valid && (cnt_q == CW'(WIDTH - 1));
    // A flush discards the held word, so it also blocks the transfer.
    load = !flush && out_free &&
           (((state_q == StCollect) && last_bit) || (state_q == StHold));
    load_data = (state_q == StHold) ? sh_q : sh_next;
  end

  // Shifter, bit counter, collect/hold FSM and sticky overrun flag.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      sh_q      <= '0;
      cnt_q     <= '0;
      state_q   <= StCollect;
      overrun_q <= 1'b0;
    end else if (flush) begin
      sh_q      <= '0;
      cnt_q     <= '0;
      state_q   <= StCollect;
      overrun_q <= 1'b0;
    end else begin
      case (state_q)
        StCollect: begin
          if (bit_valid) begin
            sh_q <= sh_next;
            if (last_bit) begin
              if (out_free) begin
                cnt_q <= '0;
              end else begin
                cnt_q   <= CW'(WIDTH);
                state_q <= StHold;
              end
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
        end
        StHold: begin
          // Bits arriving while a word is parked are lost, even on the release cycle.
          if (bit_valid) begin
            overrun_q <= 1'b1;
          end
          if (out_free) begin
            cnt_q   <= '0;
            state_q <= StCollect;
          end
        end
        default: state_q <= StCollect;
      endcase
    end
  end

  assign bit_count = cnt_q;
  assign overrun   = overrun_q;

  word_hold_reg #(
    .WIDTH(WIDTH)
  ) u_out (
    .clk      (clk),
    .clr      (clr),
    .load     (load),
    .load_data(load_data),
    .ready    (word_ready),
    .data     (word_out),
    .valid    (word_valid),
    .out_free (out_free)
  );

endmodule
